// File: rtl/reg_fwd_scoreboard_pkg.sv
// Shared widths and forwarding-source encoding for the register forwarding scoreboard.
package reg_fwd_scoreboard_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int CPU_WIDTH      = 32;
   localparam int CSR_ADDR_WIDTH = 12;

   // SRC_PEND: a stage owns the register but has not produced its result yet.
   typedef enum logic [2:0] {
      SRC_RF   = 3'd0,
      SRC_STG  = 3'd1,
      SRC_WB   = 3'd2,
      SRC_HOLD = 3'd3,
      SRC_PEND = 3'd4,
      SRC_ZERO = 3'd5
   } fwd_src_e;

endpackage

// File: rtl/fwd_port_sel.sv
// One read-port operand mux: youngest matching stage, then writeback, then the
// one-cycle hold register, then the raw register-file value. ZERO_EN hardwires address 0.
module fwd_port_sel
   import reg_fwd_scoreboard_pkg::*;
#(
   parameter int NUM_STG = 2,
   parameter int AW      = 5,
   parameter int DW      = 32,
   parameter bit ZERO_EN = 1'b1
) (
   input  logic [AW-1:0]                rd_addr,
   input  logic [DW-1:0]                rf_data,
   input  logic [NUM_STG-1:0]           stg_en,
   input  logic [NUM_STG-1:0]           stg_vld,
   input  logic [NUM_STG-1:0][AW-1:0]   stg_addr,
   input  logic [NUM_STG-1:0][DW-1:0]   stg_data,
   input  logic                         wb_en,
   input  logic [AW-1:0]                wb_addr,
   input  logic [DW-1:0]                wb_data,
   input  logic                         hold_vld,
   input  logic [AW-1:0]                hold_addr,
   input  logic [DW-1:0]                hold_data,
   input  logic                         busy,
   output logic [DW-1:0]                data,
   output logic                         fwd,
   output logic                         stall
);

   fwd_src_e        src;
   logic            stg_hit;
   logic            stg_vld_sel;
   logic [DW-1:0]   stg_data_sel;

   always_comb begin
      stg_hit      = 1'b0;
      stg_vld_sel  = 1'b0;
      stg_data_sel = '0;
      // Walk oldest to youngest so the youngest match is the one left standing.
      for (int s = NUM_STG - 1; s >= 0; s--) begin
         if (stg_en[s] && stg_addr[s] == rd_addr) begin
            stg_hit      = 1'b1;
            stg_vld_sel  = stg_vld[s];
            stg_data_sel = stg_data[s];
         end
      end

      if (ZERO_EN && rd_addr == '0)                src = SRC_ZERO;
      else if (stg_hit)                            src = stg_vld_sel ? SRC_STG : SRC_PEND;
      else if (wb_en && wb_addr == rd_addr)        src = SRC_WB;
      else if (hold_vld && hold_addr == rd_addr)   src = SRC_HOLD;
      else                                         src = SRC_RF;
   end

   always_comb begin
      data  = rf_data;
      fwd   = 1'b0;
      stall = 1'b0;
      case (src)
         SRC_ZERO: data = '0;
         SRC_STG:  begin data = stg_data_sel; fwd = 1'b1; end
         SRC_WB:   begin data = wb_data;      fwd = 1'b1; end
         SRC_HOLD: begin data = hold_data;    fwd = 1'b1; stall = busy; end
         SRC_PEND: stall = 1'b1;
         default:  stall = busy;
      endcase
   end

endmodule

// File: rtl/reg_fwd_scoreboard.sv
// Operand forwarding plus long-latency write scoreboard for NUM_RD read ports.
// Optional CSR forwarding channel is built when REG_FWD_CSR_EN is defined.
module reg_fwd_scoreboard
   import reg_fwd_scoreboard_pkg::*;
#(
   parameter int NUM_RD  = 2,
   parameter int NUM_STG = 2,
   parameter int MAX_OUT = 4
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_STG-1:0]                      stg_wr_en_i,
   input  logic [NUM_STG-1:0]                      stg_wr_vld_i,
   input  logic [NUM_STG-1:0][REG_ADDR_WIDTH-1:0]  stg_wr_addr_i,
   input  logic [NUM_STG-1:0][CPU_WIDTH-1:0]       stg_wr_data_i,
   input  logic                                    wb_wr_en_i,
   input  logic [REG_ADDR_WIDTH-1:0]               wb_wr_addr_i,
   input  logic [CPU_WIDTH-1:0]                    wb_wr_data_i,
   input  logic [NUM_RD-1:0][REG_ADDR_WIDTH-1:0]   rd_addr_i,
   input  logic [NUM_RD-1:0][CPU_WIDTH-1:0]        rf_rd_data_i,
   output logic [NUM_RD-1:0][CPU_WIDTH-1:0]        rd_data_o,
   output logic [NUM_RD-1:0]                       rd_fwd_o,
   input  logic                                    iss_vld_i,
   input  logic                                    iss_long_i,
   input  logic [REG_ADDR_WIDTH-1:0]               iss_addr_i,
   output logic                                    iss_rdy_o,
   input  logic                                    cmp_vld_i,
   input  logic [REG_ADDR_WIDTH-1:0]               cmp_addr_i,
`ifdef REG_FWD_CSR_EN
   input  logic [NUM_STG-1:0]                      csr_stg_wr_en_i,
   input  logic [NUM_STG-1:0]                      csr_stg_wr_vld_i,
   input  logic [NUM_STG-1:0][CSR_ADDR_WIDTH-1:0]  csr_stg_wr_addr_i,
   input  logic [NUM_STG-1:0][CPU_WIDTH-1:0]       csr_stg_wr_data_i,
   input  logic                                    csr_wb_wr_en_i,
   input  logic [CSR_ADDR_WIDTH-1:0]               csr_wb_wr_addr_i,
   input  logic [CPU_WIDTH-1:0]                    csr_wb_wr_data_i,
   input  logic [CSR_ADDR_WIDTH-1:0]               csr_rd_addr_i,
   input  logic [CPU_WIDTH-1:0]                    csr_rf_data_i,
   output logic [CPU_WIDTH-1:0]                    csr_rd_data_o,
   output logic                                    csr_rd_fwd_o,
`endif
   output logic                                    stall_o,
   output logic                                    err_o
);

   localparam int CNT_W   = $clog2(MAX_OUT + 1);
   localparam int NUM_REG = 1 << REG_ADDR_WIDTH;

   logic [NUM_REG-1:0]         busy;
   logic [CNT_W-1:0]           cnt;
   logic                       hold_vld;
   logic [REG_ADDR_WIDTH-1:0]  hold_addr;
   logic [CPU_WIDTH-1:0]       hold_data;
   logic                       hold_load;
   logic                       cmp_hit;
   logic                       iss_req;
   logic                       iss_acc;
   logic [NUM_RD-1:0]          port_stall;
   logic                       csr_stall;

   // A completing entry frees its slot and its register for an issue in the same cycle.
   always_comb begin
      cmp_hit   = cmp_vld_i && busy[cmp_addr_i];
      iss_req   = iss_vld_i && iss_long_i;
      iss_rdy_o = (cmp_hit || cnt != CNT_W'(MAX_OUT)) &&
                  (!busy[iss_addr_i] || (cmp_hit && cmp_addr_i == iss_addr_i));
      iss_acc   = iss_req && iss_rdy_o && iss_addr_i != '0;
      hold_load = wb_wr_en_i && wb_wr_addr_i != '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         cnt      <= '0;
         err_o    <= 1'b0;
         hold_vld <= 1'b0;
      end else begin
         if (cmp_hit) busy[cmp_addr_i] <= 1'b0;
         if (iss_acc) busy[iss_addr_i] <= 1'b1;
         if (iss_acc && !cmp_hit)      cnt <= cnt + CNT_W'(1);
         else if (!iss_acc && cmp_hit) cnt <= cnt - CNT_W'(1);
         if ((cmp_vld_i && !cmp_hit) || (iss_req && !iss_rdy_o)) err_o <= 1'b1;
         hold_vld <= hold_load;
      end
   end

   always_ff @(posedge clk) begin
      if (hold_load) begin
         hold_addr <= wb_wr_addr_i;
         hold_data <= wb_wr_data_i;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_port
      fwd_port_sel #(
         .NUM_STG (NUM_STG),
         .AW      (REG_ADDR_WIDTH),
         .DW      (CPU_WIDTH),
         .ZERO_EN (1'b1)
      ) u_sel (
         .rd_addr   (rd_addr_i[p]),
         .rf_data   (rf_rd_data_i[p]),
         .stg_en    (stg_wr_en_i),
         .stg_vld   (stg_wr_vld_i),
         .stg_addr  (stg_wr_addr_i),
         .stg_data  (stg_wr_data_i),
         .wb_en     (wb_wr_en_i),
         .wb_addr   (wb_wr_addr_i),
         .wb_data   (wb_wr_data_i),
         .hold_vld  (hold_vld),
         .hold_addr (hold_addr),
         .hold_data (hold_data),
         .busy      (busy[rd_addr_i[p]]),
         .data      (rd_data_o[p]),
         .fwd       (rd_fwd_o[p]),
         .stall     (port_stall[p])
      );
   end

`ifdef REG_FWD_CSR_EN
   logic                       csr_hold_vld;
   logic [CSR_ADDR_WIDTH-1:0]  csr_hold_addr;
   logic [CPU_WIDTH-1:0]       csr_hold_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) csr_hold_vld <= 1'b0;
      else     csr_hold_vld <= csr_wb_wr_en_i;
   end

   always_ff @(posedge clk) begin
      if (csr_wb_wr_en_i) begin
         csr_hold_addr <= csr_wb_wr_addr_i;
         csr_hold_data <= csr_wb_wr_data_i;
      end
   end

   fwd_port_sel #(
      .NUM_STG (NUM_STG),
      .AW      (CSR_ADDR_WIDTH),
      .DW      (CPU_WIDTH),
      .ZERO_EN (1'b0)
   ) u_csr_sel (
      .rd_addr   (csr_rd_addr_i),
      .rf_data   (csr_rf_data_i),
      .stg_en    (csr_stg_wr_en_i),
      .stg_vld   (csr_stg_wr_vld_i),
      .stg_addr  (csr_stg_wr_addr_i),
      .stg_data  (csr_stg_wr_data_i),
      .wb_en     (csr_wb_wr_en_i),
      .wb_addr   (csr_wb_wr_addr_i),
      .wb_data   (csr_wb_wr_data_i),
      .hold_vld  (csr_hold_vld),
      .hold_addr (csr_hold_addr),
      .hold_data (csr_hold_data),
      .busy      (1'b0),
      .data      (csr_rd_data_o),
      .fwd       (csr_rd_fwd_o),
      .stall     (csr_stall)
   );
`else
   assign csr_stall = 1'b0;
`endif

   assign stall_o = !rst && (|port_stall || csr_stall);

endmodule

// File: tb/tb_reg_fwd_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_reg_fwd_scoreboard;
   import reg_fwd_scoreboard_pkg::*;

   localparam int NUM_RD  = 2;
   localparam int NUM_STG = 2;
   localparam int MAX_OUT = 4;
   localparam int AW      = REG_ADDR_WIDTH;
   localparam int DW      = CPU_WIDTH;

   logic                              clk = 1'b0;
   logic                              rst;
   logic [NUM_STG-1:0]                stg_wr_en_i, stg_wr_vld_i;
   logic [NUM_STG-1:0][AW-1:0]        stg_wr_addr_i;
   logic [NUM_STG-1:0][DW-1:0]        stg_wr_data_i;
   logic                              wb_wr_en_i;
   logic [AW-1:0]                     wb_wr_addr_i;
   logic [DW-1:0]                     wb_wr_data_i;
   logic [NUM_RD-1:0][AW-1:0]         rd_addr_i;
   logic [NUM_RD-1:0][DW-1:0]         rf_rd_data_i;
   logic [NUM_RD-1:0][DW-1:0]         rd_data_o;
   logic [NUM_RD-1:0]                 rd_fwd_o;
   logic                              iss_vld_i, iss_long_i;
   logic [AW-1:0]                     iss_addr_i;
   logic                              iss_rdy_o;
   logic                              cmp_vld_i;
   logic [AW-1:0]                     cmp_addr_i;
   logic                              stall_o, err_o;

   reg_fwd_scoreboard #(.NUM_RD(NUM_RD), .NUM_STG(NUM_STG), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst),
      .stg_wr_en_i(stg_wr_en_i), .stg_wr_vld_i(stg_wr_vld_i),
      .stg_wr_addr_i(stg_wr_addr_i), .stg_wr_data_i(stg_wr_data_i),
      .wb_wr_en_i(wb_wr_en_i), .wb_wr_addr_i(wb_wr_addr_i), .wb_wr_data_i(wb_wr_data_i),
      .rd_addr_i(rd_addr_i), .rf_rd_data_i(rf_rd_data_i),
      .rd_data_o(rd_data_o), .rd_fwd_o(rd_fwd_o),
      .iss_vld_i(iss_vld_i), .iss_long_i(iss_long_i), .iss_addr_i(iss_addr_i),
      .iss_rdy_o(iss_rdy_o), .cmp_vld_i(cmp_vld_i), .cmp_addr_i(cmp_addr_i),
      .stall_o(stall_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state: which registers await a long write, how many, the
   // sticky error, and the last writeback (visible for one cycle).
   bit            mbusy [1<<AW];
   int            mcnt;
   bit            merr;
   bit            mhv;
   logic [AW-1:0] mha;
   logic [DW-1:0] mhd;

   function automatic void model_reset();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      mcnt = 0; merr = 1'b0; mhv = 1'b0;
   endfunction

   function automatic bit model_rdy();
      int c = mcnt;
      bit b = mbusy[iss_addr_i];
      if (cmp_vld_i && mbusy[cmp_addr_i]) begin
         c = c - 1;
         if (cmp_addr_i == iss_addr_i) b = 1'b0;
      end
      return (c < MAX_OUT) && !b;
   endfunction

   function automatic void model_read(input int p, output logic [DW-1:0] d, output bit f,
                                      output bit st);
      logic [AW-1:0] a = rd_addr_i[p];
      d = rf_rd_data_i[p]; f = 1'b0; st = 1'b0;
      if (a == 0) begin d = '0; return; end
      for (int s = 0; s < NUM_STG; s++)
         if (stg_wr_en_i[s] && stg_wr_addr_i[s] == a) begin
            if (stg_wr_vld_i[s]) begin d = stg_wr_data_i[s]; f = 1'b1; end
            else st = 1'b1;
            return;
         end
      if (wb_wr_en_i && wb_wr_addr_i == a) begin d = wb_wr_data_i; f = 1'b1; return; end
      if (mhv && mha == a) begin d = mhd; f = 1'b1; end
      st = mbusy[a];
   endfunction

   task automatic idle();
      stg_wr_en_i = '0; stg_wr_vld_i = '0; stg_wr_addr_i = '0; stg_wr_data_i = '0;
      wb_wr_en_i = 1'b0; wb_wr_addr_i = '0; wb_wr_data_i = '0;
      rd_addr_i = '0;
      for (int p = 0; p < NUM_RD; p++) rf_rd_data_i[p] = $urandom;
      iss_vld_i = 1'b0; iss_long_i = 1'b0; iss_addr_i = '0;
      cmp_vld_i = 1'b0; cmp_addr_i = '0;
   endtask

   task automatic step();
      bit hit = cmp_vld_i && mbusy[cmp_addr_i];
      bit rdy = model_rdy();
      bit acc = iss_vld_i && iss_long_i && rdy && iss_addr_i != 0;
      bit bad = (cmp_vld_i && !hit) || (iss_vld_i && iss_long_i && !rdy);
      bit cap = wb_wr_en_i && wb_wr_addr_i != 0;
      logic [AW-1:0] ca = cmp_addr_i, ia = iss_addr_i, wa = wb_wr_addr_i;
      logic [DW-1:0] wd = wb_wr_data_i;
      @(posedge clk);
      if (hit) begin mbusy[ca] = 1'b0; mcnt--; end
      if (acc) begin mbusy[ia] = 1'b1; mcnt++; end
      merr = merr | bad;
      mhv = cap;
      if (cap) begin mha = wa; mhd = wd; end
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      stg_wr_en_i[0] = 1'b1; stg_wr_addr_i[0] = 5'd4; rd_addr_i[0] = 5'd4;
      rf_rd_data_i[0] = 32'hCAFE_0004;
      repeat (2) @(posedge clk);
      #2;
      n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b exp 0", stall_o); end
      n_cmp++; if (iss_rdy_o !== 1'b1) begin n_bad++; $display("FAIL rst_rdy got %b exp 1", iss_rdy_o); end
      n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b exp 0", err_o); end
      n_cmp++; if (rd_data_o[0] !== 32'hCAFE_0004) begin n_bad++; $display("FAIL rst_rfdata got %h exp cafe0004", rd_data_o[0]); end
      n_cmp++; if (rd_data_o[1] !== '0 || rd_fwd_o[1] !== 1'b0) begin n_bad++; $display("FAIL rst_x0 got %h/%b exp 0/0", rd_data_o[1], rd_fwd_o[1]); end
      rst = 1'b0;
      model_reset();
      idle();
      @(posedge clk); #1;
   endtask

   task automatic test_stage_priority();
      idle();
      stg_wr_en_i = 2'b11; stg_wr_vld_i = 2'b11;
      stg_wr_addr_i[0] = 5'd5; stg_wr_addr_i[1] = 5'd5;
      stg_wr_data_i[0] = 32'h11; stg_wr_data_i[1] = 32'h22;
      rd_addr_i[0] = 5'd5; rd_addr_i[1] = 5'd0;
      #2;
      n_cmp++; if (rd_data_o[0] !== 32'h11) begin n_bad++; $display("FAIL youngest_data got %h exp 11", rd_data_o[0]); end
      n_cmp++; if (rd_fwd_o[0] !== 1'b1) begin n_bad++; $display("FAIL youngest_fwd got %b exp 1", rd_fwd_o[0]); end
      n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL youngest_stall got %b exp 0", stall_o); end
      n_cmp++; if (rd_data_o[1] !== '0) begin n_bad++; $display("FAIL x0_data got %h exp 0", rd_data_o[1]); end
      step();
   endtask

   task automatic test_pending_stall();
      idle();
      stg_wr_en_i[0] = 1'b1; stg_wr_addr_i[0] = 5'd7; rd_addr_i[0] = 5'd7;
      rf_rd_data_i[0] = 32'h1234;
      #2;
      n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL pend_stall got %b exp 1", stall_o); end
      n_cmp++; if (rd_data_o[0] !== 32'h1234) begin n_bad++; $display("FAIL pend_data got %h exp 1234", rd_data_o[0]); end
      step();
      stg_wr_vld_i[0] = 1'b1; stg_wr_data_i[0] = 32'hAB;
      #2;
      n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL ready_stall got %b exp 0", stall_o); end
      n_cmp++; if (rd_data_o[0] !== 32'hAB) begin n_bad++; $display("FAIL ready_data got %h exp ab", rd_data_o[0]); end
      step();
   endtask

   task automatic test_long_issue();
      idle();
      iss_vld_i = 1'b1; iss_long_i = 1'b1; iss_addr_i = 5'd3;
      #2;
      n_cmp++; if (iss_rdy_o !== 1'b1) begin n_bad++; $display("FAIL iss3_rdy got %b exp 1", iss_rdy_o); end
      step();
      idle();
      rd_addr_i[0] = 5'd3;
      #2;
      n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL busy_stall got %b exp 1", stall_o); end
      step();
      cmp_vld_i = 1'b1; cmp_addr_i = 5'd3;
      wb_wr_en_i = 1'b1; wb_wr_addr_i = 5'd3; wb_wr_data_i = 32'h55;
      #2;
      n_cmp++; if (rd_data_o[0] !== 32'h55 || stall_o !== 1'b0) begin n_bad++; $display("FAIL cmp_wb got %h/%b exp 55/0", rd_data_o[0], stall_o); end
      step();
      idle();
      rd_addr_i[0] = 5'd3;
      #2;
      n_cmp++; if (rd_data_o[0] !== 32'h55 || stall_o !== 1'b0) begin n_bad++; $display("FAIL after_cmp got %h/%b exp 55/0", rd_data_o[0], stall_o); end
      step();
   endtask

   task automatic test_max_out();
      idle();
      for (int r = 1; r <= MAX_OUT; r++) begin
         iss_vld_i = 1'b1; iss_long_i = 1'b1; iss_addr_i = AW'(r);
         #2;
         n_cmp++; if (iss_rdy_o !== 1'b1) begin n_bad++; $display("FAIL fill_rdy x%0d got %b exp 1", r, iss_rdy_o); end
         step();
      end
      iss_addr_i = 5'd5;
      #2;
      n_cmp++; if (iss_rdy_o !== 1'b0) begin n_bad++; $display("FAIL full_rdy got %b exp 0", iss_rdy_o); end
      cmp_vld_i = 1'b1; cmp_addr_i = 5'd1;
      #2;
      n_cmp++; if (iss_rdy_o !== 1'b1) begin n_bad++; $display("FAIL swap_rdy got %b exp 1", iss_rdy_o); end
      step();
      idle();
      iss_vld_i = 1'b1; iss_long_i = 1'b1; iss_addr_i = 5'd6;
      rd_addr_i[0] = 5'd1;
      #2;
      n_cmp++; if (iss_rdy_o !== 1'b0) begin n_bad++; $display("FAIL still_full got %b exp 0", iss_rdy_o); end
      n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL x1_freed got %b exp 0", stall_o); end
      rd_addr_i[0] = 5'd5;
      #1;
      n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL x5_busy got %b exp 1", stall_o); end
      n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL no_err got %b exp 0", err_o); end
      idle();
      for (int r = 2; r <= 5; r++) begin
         cmp_vld_i = 1'b1; cmp_addr_i = AW'(r);
         step();
      end
      idle();
      iss_vld_i = 1'b1; iss_long_i = 1'b1; iss_addr_i = 5'd6;
      #2;
      n_cmp++; if (iss_rdy_o !== 1'b1) begin n_bad++; $display("FAIL drained_rdy got %b exp 1", iss_rdy_o); end
      iss_vld_i = 1'b0;
      step();
   endtask

   task automatic test_hold();
      idle();
      wb_wr_en_i = 1'b1; wb_wr_addr_i = 5'd9; wb_wr_data_i = 32'hDEAD;
      step();
      idle();
      rd_addr_i[1] = 5'd9; rf_rd_data_i[1] = 32'h0;
      #2;
      n_cmp++; if (rd_data_o[1] !== 32'hDEAD || rd_fwd_o[1] !== 1'b1) begin n_bad++; $display("FAIL hold_data got %h/%b exp dead/1", rd_data_o[1], rd_fwd_o[1]); end
      step();
      #2;
      n_cmp++; if (rd_data_o[1] !== 32'h0 || rd_fwd_o[1] !== 1'b0) begin n_bad++; $display("FAIL hold_expire got %h/%b exp 0/0", rd_data_o[1], rd_fwd_o[1]); end
      step();
   endtask

   task automatic test_error();
      idle();
      cmp_vld_i = 1'b1; cmp_addr_i = 5'd12;
      step();
      idle();
      #2;
      n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_set got %b exp 1", err_o); end
      step();
      #2;
      n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b exp 1", err_o); end
   endtask

   task automatic test_random();
      logic [DW-1:0] ed;
      bit ef, es, est;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int s = 0; s < NUM_STG; s++) begin
            stg_wr_en_i[s] = $urandom_range(0, 1); stg_wr_vld_i[s] = $urandom_range(0, 1);
            stg_wr_addr_i[s] = AW'($urandom_range(0, 7)); stg_wr_data_i[s] = $urandom;
         end
         wb_wr_en_i = $urandom_range(0, 1); wb_wr_addr_i = AW'($urandom_range(0, 7));
         wb_wr_data_i = $urandom;
         for (int p = 0; p < NUM_RD; p++) begin
            rd_addr_i[p] = AW'($urandom_range(0, 7)); rf_rd_data_i[p] = $urandom;
         end
         iss_vld_i = $urandom_range(0, 1); iss_long_i = $urandom_range(0, 1);
         iss_addr_i = AW'($urandom_range(0, 7));
         cmp_vld_i = ($urandom_range(0, 3) == 0); cmp_addr_i = AW'($urandom_range(0, 7));
         #2;
         est = 1'b0;
         for (int p = 0; p < NUM_RD; p++) begin
            model_read(p, ed, ef, es);
            est = est | es;
            n_cmp++; if (rd_data_o[p] !== ed) begin n_bad++; $display("FAIL rnd_data c%0d p%0d got %h exp %h", cyc, p, rd_data_o[p], ed); end
            n_cmp++; if (rd_fwd_o[p] !== ef) begin n_bad++; $display("FAIL rnd_fwd c%0d p%0d got %b exp %b", cyc, p, rd_fwd_o[p], ef); end
         end
         n_cmp++; if (stall_o !== est) begin n_bad++; $display("FAIL rnd_stall c%0d got %b exp %b", cyc, stall_o, est); end
         n_cmp++; if (iss_rdy_o !== model_rdy()) begin n_bad++; $display("FAIL rnd_rdy c%0d got %b exp %b", cyc, iss_rdy_o, model_rdy()); end
         n_cmp++; if (err_o !== merr) begin n_bad++; $display("FAIL rnd_err c%0d got %b exp %b", cyc, err_o, merr); end
         step();
      end
   endtask

   task automatic test_reset_mid();
      idle();
      for (int r = 2; r <= 3; r++) begin
         iss_vld_i = 1'b1; iss_long_i = 1'b1; iss_addr_i = AW'(r);
         step();
      end
      idle();
      cmp_vld_i = 1'b1; cmp_addr_i = 5'd20;
      step();
      idle();
      rd_addr_i[0] = 5'd2; rd_addr_i[1] = 5'd3;
      iss_vld_i = 1'b0; iss_addr_i = 5'd2;
      #1;
      n_cmp++; if (stall_o !== 1'b1 || err_o !== 1'b1) begin n_bad++; $display("FAIL pre_rst got %b/%b exp 1/1", stall_o, err_o); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_err got %b exp 0", err_o); end
      n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_stall got %b exp 0", stall_o); end
      n_cmp++; if (iss_rdy_o !== 1'b1) begin n_bad++; $display("FAIL mid_rst_rdy got %b exp 1", iss_rdy_o); end
      #1 rst = 1'b0;
      model_reset();
      #1;
      n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL post_rst_busy got %b exp 0", stall_o); end
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_stage_priority();
      test_pending_stall();
      test_long_issue();
      test_max_out();
      test_hold();
      test_error();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_fwd_scoreboard.md
REG_FWD_SCOREBOARD -- requirements
Module: reg_fwd_scoreboard

Interface
REQ-001 SHALL have parameter NUM_RD, default 2: number of register read ports.
REQ-002 SHALL have parameter NUM_STG, default 2: number of forwarding stages; index 0 is the youngest.
REQ-003 SHALL have parameter MAX_OUT, default 4: maximum number of outstanding long-latency writes.
REQ-004 SHALL have port clk, input, 1: single clock; all state rises on posedge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port stg_wr_en_i, input, NUM_STG: per-stage pending register write.
REQ-007 SHALL have port stg_wr_vld_i, input, NUM_STG: per-stage write data is valid; 0 means the result is not yet produced.
REQ-008 SHALL have ports stg_wr_addr_i and stg_wr_data_i, inputs, NUM_STG x REG_ADDR_WIDTH and NUM_STG x CPU_WIDTH: per-stage destination and data.
REQ-009 SHALL have ports wb_wr_en_i, wb_wr_addr_i and wb_wr_data_i, inputs, 1, REG_ADDR_WIDTH and CPU_WIDTH: the register file write this cycle.
REQ-010 SHALL have ports rd_addr_i and rf_rd_data_i, inputs, NUM_RD x REG_ADDR_WIDTH and NUM_RD x CPU_WIDTH: read addresses and raw register file data.
REQ-011 SHALL have ports rd_data_o and rd_fwd_o, outputs, NUM_RD x CPU_WIDTH and NUM_RD: resolved operand and its forwarded flag.
REQ-012 SHALL have ports iss_vld_i, iss_long_i and iss_addr_i, inputs, 1, 1 and REG_ADDR_WIDTH: issue of an instruction; long flags a load or divide.
REQ-013 SHALL have port iss_rdy_o, output, 1: a long issue can be accepted.
REQ-014 SHALL have ports cmp_vld_i and cmp_addr_i, inputs, 1 and REG_ADDR_WIDTH: completion of a long-latency write.
REQ-015 SHALL have ports stall_o and err_o, outputs, 1 each: operand hazard stall, and sticky protocol error.

Function
REQ-016 Per port, address 0 SHALL give rd_data_o=0, rd_fwd_o=0 and never stall.
REQ-017 Priority SHALL be: stage 0..NUM_STG-1 match with en=1, then wb write, then hold register, then rf_rd_data_i.
REQ-018 If the winning stage match has vld=0, the port SHALL assert stall_o and drive rf_rd_data_i.
REQ-019 If rd_addr is busy in the scoreboard and no stage or wb source with valid data matches, the port SHALL stall.
REQ-020 stall_o SHALL be the OR over all ports, combinational with zero-cycle latency.
REQ-021 The hold register SHALL capture the wb write on every posedge with wb_wr_en_i=1 and wb_wr_addr_i!=0; it SHALL then serve exactly one following cycle unless it is overwritten.
REQ-022 The scoreboard SHALL hold one busy bit per register and a counter, 0..MAX_OUT.
REQ-023 An accepted long issue (iss_vld_i && iss_long_i && iss_rdy_o && addr!=0) SHALL set busy and increment the counter at the next edge.
REQ-024 Completion of a busy address SHALL clear busy and decrement the counter.
REQ-025 iss_rdy_o SHALL be 0 when the counter equals MAX_OUT or iss_addr_i is already busy; otherwise iss_rdy_o SHALL be 1.
REQ-026 When an issue and a completion hit the same address in one cycle, busy SHALL stay 1 and the counter SHALL be unchanged.
REQ-027 When an issue and a completion hit different addresses in one cycle, both SHALL apply and the counter SHALL be unchanged.
REQ-028 Completion of a non-busy address, or an issue with iss_rdy_o=0, SHALL be ignored and SHALL set err_o.

Reset
REQ-029 rst SHALL asynchronously clear the busy bits, the counter, the hold valid bit and err_o, including mid-operation.
REQ-030 During rst, stall_o SHALL be 0 and iss_rdy_o SHALL be 1.
REQ-031 During rst, rd_data_o SHALL follow the combinational rules with every state element cleared.

Configuration
REQ-032 With REG_FWD_CSR_EN defined, the block SHALL add a CSR channel: the same per-stage and wb inputs at CSR_ADDR_WIDTH, csr_rd_addr_i, csr_rf_data_i and csr_rd_data_o, with the REQ-017 priority and no address-0 exception.
REQ-033 Without REG_FWD_CSR_EN, the CSR ports and logic SHALL be absent.

Structure
REQ-034 REG_ADDR_WIDTH, CPU_WIDTH, CSR_ADDR_WIDTH and the forwarding-source select encoding SHALL live in the shared defines package.
REQ-035 The per-port mux SHALL be the sub-module fwd_port_sel, instantiated NUM_RD times by generate.

Verification
REQ-036 Stage0 and stage1 both write x5 (data 0x11, 0x22, vld=1), then read x5 -> rd_data 0x11, rd_fwd=1.
REQ-037 Stage0 writes x7 with vld=0, then read x7 -> stall_o=1; on the next cycle with vld=1 and data 0xAB -> stall_o=0, data 0xAB.
REQ-038 Long issue x3, then read x3 with no match -> stall; cmp x3 together with a wb write of 0x55 -> data 0x55 and no stall.
REQ-039 MAX_OUT=4 long issues to x1..x4 -> iss_rdy_o=0; a same-cycle issue x5 and cmp x1 -> counter stays 4.
REQ-040 Wb writes x9=0xDEAD; the next cycle reads x9 with the raw rf data stale -> data 0xDEAD from the hold register.
REQ-041 Assert rst mid-run with busy bits set -> busy, counter and err_o clear immediately, and stall_o=0.
